// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage RV32I pipeline: stage enables, bubble/squash,
// PC redirect, EX operand forwarding selects and stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW       = 5,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic              ex_br_taken,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_we,
    input  logic              mem_busy,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              decode_bubble,
    output logic              squash,
    output logic              pc_redirect,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [1:0] SEL_RF  = 2'd0;
    localparam logic [1:0] SEL_EX  = 2'd1;
    localparam logic [1:0] SEL_MEM = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic ex_fwd_ok;
    logic mem_fwd_ok;
    logic load_use;

    // x0 is hardwired zero, so a zero destination never produces a hazard or forward
    always_comb begin
        ex_fwd_ok  = ex_valid & ex_reg_we & ~ex_is_load & (ex_rd != '0);
        mem_fwd_ok = mem_valid & mem_reg_we & (mem_rd != '0);
        load_use   = ex_valid & ex_is_load & ex_reg_we & id_valid & (ex_rd != '0) &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    end

    always_comb begin
        fwd_rs1_sel = SEL_RF;
        fwd_rs2_sel = SEL_RF;
        if (!rst) begin
            if (ex_fwd_ok && (id_rs1 == ex_rd))         fwd_rs1_sel = SEL_EX;
            else if (mem_fwd_ok && (id_rs1 == mem_rd))  fwd_rs1_sel = SEL_MEM;
            if (ex_fwd_ok && (id_rs2 == ex_rd))         fwd_rs2_sel = SEL_EX;
            else if (mem_fwd_ok && (id_rs2 == mem_rd))  fwd_rs2_sel = SEL_MEM;
        end
    end

    // Priority: reset > memory hold > taken branch > load-use
    always_comb begin
        state_d       = state_q;
        fcnt_d        = fcnt_q;
        fetch_en      = 1'b1;
        decode_en     = 1'b1;
        exec_en       = 1'b1;
        decode_bubble = 1'b0;
        squash        = 1'b0;
        pc_redirect   = 1'b0;
        if (rst) begin
            fetch_en  = 1'b0;
            decode_en = 1'b0;
            exec_en   = 1'b0;
            squash    = 1'b1;
            state_d   = ST_RUN;
            fcnt_d    = '0;
        end else if (mem_busy) begin
            fetch_en  = 1'b0;
            decode_en = 1'b0;
            exec_en   = 1'b0;
        end else begin
            case (state_q)
                ST_RUN, ST_LOAD_STALL: begin
                    if (ex_valid && ex_br_taken) begin
                        pc_redirect = 1'b1;
                        squash      = 1'b1;
                        fcnt_d      = FC_INIT;
                        state_d     = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
                    end else if ((state_q == ST_RUN) && load_use) begin
                        fetch_en      = 1'b0;
                        decode_en     = 1'b0;
                        decode_bubble = 1'b1;
                        state_d       = ST_LOAD_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    // Wrong-path branches resolving here are ignored
                    squash = 1'b1;
                    if (fcnt_q <= FC_W'(1)) begin
                        fcnt_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - FC_W'(1);
                    end
                end
                default: begin
                    squash  = 1'b1;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if ((decode_bubble || mem_busy) && (stall_count_q != {CNT_W{1'b1}}))
            stall_count_d = stall_count_q + CNT_W'(1);
        if (pc_redirect && (flush_count_q != {CNT_W{1'b1}}))
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            fcnt_q        <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            fcnt_q        <= fcnt_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign state       = state_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table through an expected-result queue,
// plus hand sequences for counter saturation, repeated redirects and reset of the counters.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          id_valid, id_use_rs1, id_use_rs2;
    logic [AW-1:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic          ex_valid, ex_reg_we, ex_is_load, ex_br_taken;
    logic          mem_valid, mem_reg_we, mem_busy;
    logic          fetch_en, decode_en, exec_en, decode_bubble, squash, pc_redirect;
    logic [1:0]    fwd_rs1_sel, fwd_rs2_sel, state;
    logic [CW-1:0] stall_count, flush_count;

    pipeline_hazard_ctrl #(.REG_AW(AW), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_reg_we(ex_reg_we),
        .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_reg_we(mem_reg_we), .mem_busy(mem_busy),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .decode_bubble(decode_bubble), .squash(squash), .pc_redirect(pc_redirect),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          rst;
        logic          idv;
        logic [AW-1:0] rs1;
        logic          u1;
        logic [AW-1:0] rs2;
        logic          u2;
        logic          exv;
        logic [AW-1:0] exrd;
        logic          exwe;
        logic          exld;
        logic          exbr;
        logic          memv;
        logic [AW-1:0] memrd;
        logic          memwe;
        logic          busy;
    } in_t;

    typedef struct packed {
        logic [2:0]    en;
        logic          bub;
        logic          sq;
        logic          rdr;
        logic [1:0]    f1;
        logic [1:0]    f2;
        logic [1:0]    st;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;
    int   pulses;

    function automatic in_t mk_in(input int r, input int idv, input int rs1, input int u1,
                                  input int rs2, input int u2, input int exv, input int exrd,
                                  input int exwe, input int exld, input int exbr, input int memv,
                                  input int memrd, input int memwe, input int busy);
        in_t v;
        v.rst  = 1'(r);    v.idv  = 1'(idv);
        v.rs1  = AW'(rs1); v.u1   = 1'(u1);
        v.rs2  = AW'(rs2); v.u2   = 1'(u2);
        v.exv  = 1'(exv);  v.exrd = AW'(exrd);
        v.exwe = 1'(exwe); v.exld = 1'(exld); v.exbr = 1'(exbr);
        v.memv = 1'(memv); v.memrd = AW'(memrd); v.memwe = 1'(memwe);
        v.busy = 1'(busy);
        return v;
    endfunction

    function automatic exp_t mk_exp(input int en, input int bub, input int sq, input int rdr,
                                    input int f1, input int f2, input int st, input int sc,
                                    input int fc);
        exp_t e;
        e.en = 3'(en); e.bub = 1'(bub); e.sq = 1'(sq); e.rdr = 1'(rdr);
        e.f1 = 2'(f1); e.f2 = 2'(f2); e.st = 2'(st);
        e.sc = CW'(sc); e.fc = CW'(fc);
        return e;
    endfunction

    function automatic in_t idle();
        return mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t v);
        rst = v.rst;       id_valid = v.idv;
        id_rs1 = v.rs1;    id_use_rs1 = v.u1;
        id_rs2 = v.rs2;    id_use_rs2 = v.u2;
        ex_valid = v.exv;  ex_rd = v.exrd;
        ex_reg_we = v.exwe; ex_is_load = v.exld; ex_br_taken = v.exbr;
        mem_valid = v.memv; mem_rd = v.memrd; mem_reg_we = v.memwe;
        mem_busy = v.busy;
    endtask

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic compare(input int k, input exp_t e);
        chk($sformatf("v%0d.en", k),   {fetch_en, decode_en, exec_en}, e.en);
        chk($sformatf("v%0d.bub", k),  decode_bubble, e.bub);
        chk($sformatf("v%0d.sq", k),   squash, e.sq);
        chk($sformatf("v%0d.rdr", k),  pc_redirect, e.rdr);
        chk($sformatf("v%0d.fwd1", k), fwd_rs1_sel, e.f1);
        chk($sformatf("v%0d.fwd2", k), fwd_rs2_sel, e.f2);
        chk($sformatf("v%0d.st", k),   state, e.st);
        chk($sformatf("v%0d.stall", k), stall_count, e.sc);
        chk($sformatf("v%0d.flush", k), flush_count, e.fc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        pulses   = 0;

        // First reset cycle: registered state still unknown, check forced controls only
        drive(mk_in(1, 1, 3, 1, 0, 0, 1, 3, 1, 0, 1, 1, 3, 1, 0));
        @(negedge clk);
        chk("rst0.en", {fetch_en, decode_en, exec_en}, 0);
        chk("rst0.sq", squash, 1);
        chk("rst0.rdr", pc_redirect, 0);
        chk("rst0.bub", decode_bubble, 0);
        @(posedge clk); #1;

        //        rst idv rs1 u1 rs2 u2 exv exrd we ld br memv memrd we busy
        add(mk_in(1, 1, 3, 1, 0, 0, 1, 3, 1, 0, 1, 1, 3, 1, 0), mk_exp(0, 0, 1, 0, 0, 0, 0, 0, 0));
        add(idle(),                                            mk_exp(7, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0), mk_exp(7, 0, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(0, 1, 5, 1, 0, 0, 1, 5, 1, 1, 0, 0, 0, 0, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(mk_in(0, 1, 5, 1, 0, 0, 1, 5, 1, 1, 0, 1, 5, 1, 0), mk_exp(7, 0, 0, 0, 2, 0, 1, 1, 0));
        add(idle(),                                            mk_exp(7, 0, 0, 0, 0, 0, 0, 1, 0));
        add(mk_in(0, 1, 7, 0, 7, 1, 1, 7, 1, 0, 0, 1, 7, 1, 0), mk_exp(7, 0, 0, 0, 1, 1, 0, 1, 0));
        add(mk_in(0, 1, 7, 0, 7, 1, 0, 7, 1, 0, 0, 1, 7, 1, 0), mk_exp(7, 0, 0, 0, 2, 2, 0, 1, 0));
        add(mk_in(0, 1, 7, 0, 7, 1, 1, 7, 0, 0, 0, 1, 7, 1, 0), mk_exp(7, 0, 0, 0, 2, 2, 0, 1, 0));
        add(mk_in(0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0), mk_exp(7, 0, 0, 0, 0, 0, 0, 1, 0));
        add(mk_in(0, 1, 7, 1, 8, 1, 1, 7, 1, 0, 0, 1, 8, 1, 0), mk_exp(7, 0, 0, 0, 1, 2, 0, 1, 0));
        add(mk_in(0, 1, 4, 1, 0, 0, 1, 4, 1, 1, 1, 0, 0, 0, 0), mk_exp(7, 0, 1, 1, 0, 0, 0, 1, 0));
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), mk_exp(7, 0, 1, 0, 0, 0, 2, 1, 1));
        add(idle(),                                            mk_exp(7, 0, 0, 0, 0, 0, 0, 1, 1));
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1), mk_exp(0, 0, 0, 0, 0, 0, 0, 1, 1));
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1), mk_exp(0, 0, 0, 0, 0, 0, 0, 2, 1));
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1), mk_exp(0, 0, 0, 0, 0, 0, 0, 3, 1));
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), mk_exp(7, 0, 1, 1, 0, 0, 0, 4, 1));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), mk_exp(0, 0, 0, 0, 0, 0, 2, 4, 2));
        add(idle(),                                            mk_exp(7, 0, 1, 0, 0, 0, 2, 5, 2));
        add(idle(),                                            mk_exp(7, 0, 0, 0, 0, 0, 0, 5, 2));
        add(mk_in(0, 1, 0, 0, 9, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 5, 2));
        add(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0), mk_exp(7, 0, 1, 1, 0, 0, 1, 6, 2));
        add(idle(),                                            mk_exp(7, 0, 1, 0, 0, 0, 2, 6, 3));
        add(mk_in(0, 1, 9, 0, 9, 0, 1, 9, 1, 1, 0, 0, 0, 0, 0), mk_exp(7, 0, 0, 0, 0, 0, 0, 6, 3));
        add(mk_in(0, 0, 9, 1, 9, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0), mk_exp(7, 0, 0, 0, 0, 0, 0, 6, 3));
        add(mk_in(0, 1, 9, 1, 0, 0, 1, 9, 0, 1, 0, 0, 0, 0, 0), mk_exp(7, 0, 0, 0, 0, 0, 0, 6, 3));
        add(mk_in(0, 1, 9, 1, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0), mk_exp(7, 0, 0, 0, 0, 0, 0, 6, 3));
        add(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0), mk_exp(7, 0, 0, 0, 0, 0, 0, 6, 3));
        add(mk_in(0, 1, 9, 1, 0, 0, 1, 9, 1, 1, 0, 0, 0, 0, 1), mk_exp(0, 0, 0, 0, 0, 0, 0, 6, 3));
        add(mk_in(0, 1, 9, 1, 0, 0, 1, 9, 1, 1, 0, 0, 0, 0, 0), mk_exp(1, 1, 0, 0, 0, 0, 0, 7, 3));
        add(idle(),                                            mk_exp(7, 0, 0, 0, 0, 0, 1, 8, 3));

        foreach (vecs[k]) begin
            drive(vecs[k].i);
            exp_q.push_back(vecs[k].e);
            @(negedge clk);
            compare(k, exp_q.pop_front());
            @(posedge clk); #1;
        end

        // Long memory hold: stall counter must saturate, not wrap
        for (int c = 0; c < 10; c++) begin
            drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
            @(negedge clk);
            chk($sformatf("busy%0d.en", c), {fetch_en, decode_en, exec_en}, 0);
            @(posedge clk); #1;
        end
        drive(idle());
        @(negedge clk);
        chk("sat.stall", stall_count, 15);
        chk("sat.st", state, 0);
        @(posedge clk); #1;

        // Branch held taken: redirect on every RUN cycle, ignored in FLUSH
        for (int c = 0; c < 40; c++) begin
            drive(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0));
            @(negedge clk);
            if (pc_redirect) pulses++;
            @(posedge clk); #1;
        end
        drive(idle());
        @(negedge clk);
        chk("redir.pulses", pulses, 20);
        chk("redir.flush", flush_count, 15);
        chk("redir.stall", stall_count, 15);
        chk("redir.st", state, 0);
        @(posedge clk); #1;

        // Reset clears the counters
        drive(mk_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(idle());
        @(negedge clk);
        chk("rst2.stall", stall_count, 0);
        chk("rst2.flush", flush_count, 0);
        chk("rst2.st", state, 0);
        chk("rst2.en", {fetch_en, decode_en, exec_en}, 7);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
